// File: rtl/serial_addsub_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub_engine_pkg
//  Description : Shared state encodings and mode constants for the serial
//                add/subtract engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_addsub_engine_pkg;

    // Engine control states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operation select values for the mode input
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : serial_addsub_engine_pkg
`default_nettype wire

// File: rtl/serial_addsub_slice.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub_slice
//  Description : Combinational BPC-bit ripple-carry adder slice. Also reports
//                the carry into its top bit so the engine can derive signed
//                overflow on the final slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub_slice #(
    parameter int BPC = 1
) (
    input  logic [BPC-1:0] a,
    input  logic [BPC-1:0] b,
    input  logic           cin,
    output logic [BPC-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    logic w_c;

    // Ripple the carry through each bit, remembering the carry into the top bit
    always_comb begin
        w_c   = cin;
        sum   = '0;
        c_msb = cin;
        for (int i = 0; i < BPC; i++) begin
            if (i == BPC - 1) begin
                c_msb = w_c;
            end
            sum[i] = a[i] ^ b[i] ^ w_c;
            w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        cout = w_c;
    end

endmodule : serial_addsub_slice
`default_nettype wire

// File: rtl/serial_addsub_engine.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub_engine
//  Description : Serial WIDTH-bit adder/subtractor processing BPC bits per
//                enabled cycle, LSB first, with start/busy/done handshake,
//                carry/borrow and signed-overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub_engine
    import serial_addsub_engine_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pload,
    input  logic             enable,
    input  logic             mode,
    input  logic [WIDTH-1:0] adata,
    input  logic [WIDTH-1:0] bdata,
    output logic [WIDTH-1:0] pout,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NSTEP = WIDTH / BPC;
    localparam int CW    = $clog2(NSTEP + 1);

    if ((WIDTH < 2) || ((WIDTH % BPC) != 0) || (BPC < 1)) begin : g_param_check
        $error("serial_addsub_engine: WIDTH must be >= 2 and a multiple of BPC");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_pout;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [BPC-1:0]   w_sum;
    logic             w_slice_cout;
    logic             w_slice_cmsb;
    logic [WIDTH+BPC-1:0] w_cat;
    logic [WIDTH-1:0] w_res_next;

    // A new operation is only accepted when no computation is in flight
    assign w_load = pload && (r_state != ST_RUN);
    assign w_step = (r_state == ST_RUN) && enable;
    assign w_last = w_step && (r_cnt == CW'(NSTEP - 1));

    // New slice sum enters the result from the MSB side
    assign w_cat      = {w_sum, r_res};
    assign w_res_next = w_cat[WIDTH+BPC-1:BPC];

    serial_addsub_slice #(
        .BPC (BPC)
    ) u_slice (
        .a     (r_a_sh[BPC-1:0]),
        .b     (r_b_sh[BPC-1:0]),
        .cin   (r_carry),
        .sum   (w_sum),
        .cout  (w_slice_cout),
        .c_msb (w_slice_cmsb)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (pload)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: if (pload)  w_state_next = ST_RUN;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    // Operand shift registers, carry, step counter and result capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_pout  <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                // Subtraction is A + ~B + 1: invert B and seed the carry with 1
                r_a_sh  <= adata;
                r_b_sh  <= (mode == MODE_SUB) ? ~bdata : bdata;
                r_carry <= mode;
                r_cnt   <= '0;
                r_res   <= '0;
                r_pout  <= '0;
                r_cout  <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (w_step) begin
                r_a_sh  <= r_a_sh >> BPC;
                r_b_sh  <= r_b_sh >> BPC;
                r_carry <= w_slice_cout;
                r_res   <= w_res_next;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_pout <= w_res_next;
                    r_cout <= w_slice_cout;
                    r_ovf  <= w_slice_cmsb ^ w_slice_cout;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign pout = r_pout;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign done = r_done;
    assign busy = (r_state == ST_RUN);

endmodule : serial_addsub_engine
`default_nettype wire

// File: tb/tb_serial_addsub_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_addsub_engine
//  Description : Directed self-checking bench for serial_addsub_engine at
//                WIDTH=8/BPC=1 and WIDTH=16/BPC=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub_engine;

    logic        clk = 1'b0;
    logic        rst;

    logic        pload8, en8, mode8;
    logic [7:0]  a8, b8, pout8;
    logic        cout8, ovf8, busy8, done8;

    logic        pload16, en16, mode16;
    logic [15:0] a16, b16, pout16;
    logic        cout16, ovf16, busy16, done16;

    int vectors     = 0;
    int miscompares = 0;
    int cycles;
    int seen;

    always #5 clk = ~clk;

    serial_addsub_engine #(.WIDTH(8), .BPC(1)) u_dut8 (
        .clk(clk), .rst(rst), .pload(pload8), .enable(en8), .mode(mode8),
        .adata(a8), .bdata(b8), .pout(pout8), .cout(cout8), .ovf(ovf8),
        .busy(busy8), .done(done8)
    );

    serial_addsub_engine #(.WIDTH(16), .BPC(4)) u_dut16 (
        .clk(clk), .rst(rst), .pload(pload16), .enable(en16), .mode(mode16),
        .adata(a16), .bdata(b16), .pout(pout16), .cout(cout16), .ovf(ovf16),
        .busy(busy16), .done(done16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start an 8-bit run and count edges from the load edge until done is seen
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic m,
                        input bit stall, input bit inject, output int ncyc);
        ncyc   = -1;
        pload8 = 1'b1;
        a8     = a;
        b8     = b;
        mode8  = m;
        for (int k = 1; k <= 40; k++) begin
            en8 = (!stall) || ((k % 2) == 1);
            if (k == 2) pload8 = 1'b0;
            if (inject && k == 4) begin
                pload8 = 1'b1;
                a8     = 8'hEE;
                b8     = 8'h77;
                mode8  = ~m;
            end
            if (inject && k == 5) pload8 = 1'b0;
            @(posedge clk);
            #1;
            if (k == 1) check("busy_after_load", busy8, 1);
            if (done8) begin
                ncyc = k;
                break;
            end
        end
        pload8 = 1'b0;
        en8    = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        pload8 = 0; en8 = 0; mode8 = 0; a8 = 0; b8 = 0;
        pload16 = 0; en16 = 0; mode16 = 0; a16 = 0; b16 = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_pout8", pout8, 0);
        check("rst_flags8", {cout8, ovf8, busy8, done8}, 0);
        check("rst_pout16", pout16, 0);
        check("rst_flags16", {cout16, ovf16, busy16, done16}, 0);

        // Basic add
        run8(8'hAA, 8'h55, 1'b0, 0, 0, cycles);
        check("add_latency", cycles, 9);
        check("add_pout", pout8, 8'hFF);
        check("add_cout", cout8, 0);
        check("add_ovf", ovf8, 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", done8, 0);
        check("pout_held", pout8, 8'hFF);
        check("busy_in_done", busy8, 0);

        // Subtract with and without borrow
        run8(8'h10, 8'h20, 1'b1, 0, 0, cycles);
        check("sub_borrow_pout", pout8, 8'hF0);
        check("sub_borrow_cout", cout8, 0);
        check("sub_borrow_ovf", ovf8, 0);
        run8(8'h20, 8'h10, 1'b1, 0, 0, cycles);
        check("sub_pout", pout8, 8'h10);
        check("sub_cout", cout8, 1);

        // Signed overflow both directions
        run8(8'h7F, 8'h01, 1'b0, 0, 0, cycles);
        check("ovf_add_pout", pout8, 8'h80);
        check("ovf_add_flags", {cout8, ovf8}, 2'b01);
        run8(8'h80, 8'h01, 1'b1, 0, 0, cycles);
        check("ovf_sub_pout", pout8, 8'h7F);
        check("ovf_sub_flags", {cout8, ovf8}, 2'b11);

        // Stalled run and ignored mid-run pload
        run8(8'hAA, 8'h55, 1'b0, 1, 0, cycles);
        check("stall_latency", cycles, 17);
        check("stall_pout", pout8, 8'hFF);
        run8(8'h33, 8'h11, 1'b0, 0, 1, cycles);
        check("midload_latency", cycles, 9);
        check("midload_pout", pout8, 8'h44);
        check("midload_flags", {cout8, ovf8}, 2'b00);

        // Reset after four steps aborts the run
        pload8 = 1'b1; a8 = 8'h12; b8 = 8'h34; mode8 = 1'b0; en8 = 1'b1;
        @(posedge clk);
        #1;
        pload8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("abort_pout", pout8, 0);
        check("abort_flags", {cout8, ovf8, busy8, done8}, 0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) seen++;
        end
        check("abort_no_done", seen, 0);
        run8(8'h05, 8'h03, 1'b1, 0, 0, cycles);
        check("fresh_latency", cycles, 9);
        check("fresh_pout", pout8, 8'h02);
        check("fresh_cout", cout8, 1);

        // 16-bit, 4 bits per clock
        pload16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; mode16 = 1'b0; en16 = 1'b1;
        cycles = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 2) pload16 = 1'b0;
            @(posedge clk);
            #1;
            if (done16) begin
                cycles = k;
                break;
            end
        end
        check("w16_latency", cycles, 5);
        check("w16_pout", pout16, 16'h0000);
        check("w16_flags", {cout16, ovf16}, 2'b10);

        // Back-to-back load in the done cycle
        pload16 = 1'b1; a16 = 16'h1234; b16 = 16'h0235; mode16 = 1'b1;
        @(posedge clk);
        #1;
        pload16 = 1'b0;
        check("b2b_done_clear", done16, 0);
        check("b2b_busy", busy16, 1);
        check("b2b_pout_clear", pout16, 0);
        cycles = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done16) begin
                cycles = k;
                break;
            end
        end
        check("b2b_latency", cycles, 4);
        check("b2b_pout", pout16, 16'h0FFF);
        check("b2b_flags", {cout16, ovf16}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_addsub_engine
`default_nettype wire
